// File: rtl/hash_receiver.sv
// Reassembles a little-endian byte stream into a HASH_BYTES-wide hash and compares it against Expected.
// Also flags inter-byte gap timeouts and bytes that arrive while a completed frame is still unacknowledged.
module hash_receiver #(
  parameter int unsigned HASH_BYTES = 8,
  parameter int unsigned GAP_LIMIT  = 15
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [7:0]              Byte,
  input  logic                    ByteValid,
  input  logic [8*HASH_BYTES-1:0] Expected,
  input  logic                    Ack,
  output logic [8*HASH_BYTES-1:0] Hash,
  output logic                    Done,
  output logic                    Match,
  output logic                    Error,
  output logic                    Overrun,
  output logic [3:0]              ByteCount
);

  localparam int unsigned HASH_W   = 8 * HASH_BYTES;
  localparam logic [3:0]  CNT_LAST = 4'(HASH_BYTES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t              state_q, state_d;
  logic [HASH_W-1:0]   shreg_q, shreg_d;
  logic [HASH_W-1:0]   hash_d;
  logic                done_d, match_d, error_d, overrun_d;
  logic [3:0]          count_d;
  logic [7:0]          gap_q, gap_d;
  logic [HASH_W-1:0]   assembled_c;
  logic                last_c, gap_hit_c;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign assembled_c = {Byte, shreg_q[HASH_W-1:8]};
  assign last_c      = (ByteCount == CNT_LAST);
  assign gap_hit_c   = (gap_q == GAP_LAST);

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ByteValid) state_d = COLLECT;
      COLLECT: begin
        if (ByteValid && last_c)        state_d = DONE;
        else if (!ByteValid && gap_hit_c) state_d = IDLE;
      end
      DONE:    if (Ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    shreg_d   = shreg_q;
    hash_d    = Hash;
    done_d    = Done;
    match_d   = Match;
    error_d   = Error;
    overrun_d = Overrun;
    count_d   = ByteCount;
    gap_d     = gap_q;
    case (state_q)
      IDLE: begin
        if (ByteValid) begin
          shreg_d = assembled_c;
          count_d = 4'd1;
          error_d = 1'b0;
          gap_d   = 8'd0;
        end
      end
      COLLECT: begin
        if (ByteValid) begin
          count_d = ByteCount + 4'd1;
          gap_d   = 8'd0;
          if (last_c) begin
            hash_d  = assembled_c;
            match_d = (assembled_c == Expected);
            done_d  = 1'b1;
            shreg_d = '0;
          end else begin
            shreg_d = assembled_c;
          end
        end else if (gap_hit_c) begin
          error_d = 1'b1;
          count_d = 4'd0;
          shreg_d = '0;
          gap_d   = 8'd0;
        end else begin
          gap_d = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
        end
      end
      DONE: begin
        // Ack wins over a coincident byte, which is simply dropped.
        if (Ack) begin
          done_d    = 1'b0;
          match_d   = 1'b0;
          overrun_d = 1'b0;
          error_d   = 1'b0;
          count_d   = 4'd0;
        end else if (ByteValid) begin
          overrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      shreg_q   <= '0;
      Hash      <= '0;
      Done      <= 1'b0;
      Match     <= 1'b0;
      Error     <= 1'b0;
      Overrun   <= 1'b0;
      ByteCount <= 4'd0;
      gap_q     <= 8'd0;
    end else begin
      shreg_q   <= shreg_d;
      Hash      <= hash_d;
      Done      <= done_d;
      Match     <= match_d;
      Error     <= error_d;
      Overrun   <= overrun_d;
      ByteCount <= count_d;
      gap_q     <= gap_d;
    end
  end

endmodule

// File: tb/tb_hash_receiver.sv
// Directed bench for hash_receiver: frame assembly, match, gap timeout, overrun, Ack priority and reset.
module tb_hash_receiver;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  Byte;
  logic        ByteValid;
  logic [63:0] Expected;
  logic        Ack;
  logic [63:0] Hash;
  logic        Done;
  logic        Match;
  logic        Error;
  logic        Overrun;
  logic [3:0]  ByteCount;

  int total = 0;
  int bad   = 0;

  hash_receiver #(.HASH_BYTES(8), .GAP_LIMIT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Byte(Byte), .ByteValid(ByteValid),
    .Expected(Expected), .Ack(Ack), .Hash(Hash), .Done(Done), .Match(Match),
    .Error(Error), .Overrun(Overrun), .ByteCount(ByteCount)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drives n bytes of v back-to-back, low byte first, then drops ByteValid.
  task automatic send_bytes(input logic [63:0] v, input int n);
    logic [63:0] tx;
    tx = v;
    for (int i = 0; i < n; i++) begin
      Byte      = tx[7:0];
      ByteValid = 1'b1;
      tx        = tx >> 8;
      tick();
    end
    ByteValid = 1'b0;
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Byte = 8'h00; ByteValid = 1'b0; Expected = 64'h0; Ack = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    total++; if (Hash !== 64'h0) begin bad++; $display("FAIL reset_hash got=%h exp=%h", Hash, 64'h0); end
    total++; if ({Done, Match, Error, Overrun} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {Done, Match, Error, Overrun}); end
    total++; if (ByteCount !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ByteCount); end
  endtask

  task automatic test_normal();
    Expected = 64'h0123456789ABCDEF;
    send_bytes(64'h0123456789ABCDEF, 1);
    total++; if (ByteCount !== 4'd1) begin bad++; $display("FAIL normal_count1 got=%0d exp=1", ByteCount); end
    send_bytes(64'h0123456789ABCD, 6);
    total++; if ({Done, ByteCount} !== {1'b0, 4'd7}) begin bad++; $display("FAIL normal_byte7 got=%b/%0d exp=0/7", Done, ByteCount); end
    send_bytes(64'h01, 1);
    total++; if (Hash !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL normal_hash got=%h exp=0123456789abcdef", Hash); end
    total++; if ({Done, Match} !== 2'b11) begin bad++; $display("FAIL normal_done_match got=%b exp=11", {Done, Match}); end
    total++; if (ByteCount !== 4'd8) begin bad++; $display("FAIL normal_count8 got=%0d exp=8", ByteCount); end
    do_ack();
    total++; if ({Done, Match, ByteCount} !== {2'b00, 4'd0}) begin bad++; $display("FAIL normal_ack got=%b/%0d exp=00/0", {Done, Match}, ByteCount); end
    total++; if (Hash !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL normal_hash_hold got=%h exp=0123456789abcdef", Hash); end
  endtask

  task automatic test_mismatch();
    Expected = 64'h0123456789ABCDEE;
    send_bytes(64'h0123456789ABCDEF, 8);
    total++; if ({Done, Match} !== 2'b10) begin bad++; $display("FAIL mismatch_flags got=%b exp=10", {Done, Match}); end
    total++; if (Hash !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL mismatch_hash got=%h exp=0123456789abcdef", Hash); end
    do_ack();
  endtask

  task automatic test_gap();
    send_bytes(64'h030201, 3);
    for (int i = 0; i < 14; i++) tick();
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL gap_early got=%b exp=0", Error); end
    tick();
    total++; if ({Error, Done, ByteCount} !== {2'b10, 4'd0}) begin bad++; $display("FAIL gap_timeout got=%b/%0d exp=10/0", {Error, Done}, ByteCount); end
    tick();
    total++; if (Error !== 1'b1) begin bad++; $display("FAIL gap_sticky got=%b exp=1", Error); end
    Expected = 64'h8877665544332211;
    send_bytes(64'h11, 1);
    total++; if ({Error, ByteCount} !== {1'b0, 4'd1}) begin bad++; $display("FAIL gap_clear got=%b/%0d exp=0/1", Error, ByteCount); end
    send_bytes(64'h88776655443322, 7);
    total++; if ({Hash, Match} !== {64'h8877665544332211, 1'b1}) begin bad++; $display("FAIL gap_refill got=%h/%b exp=8877665544332211/1", Hash, Match); end
    do_ack();
    // 14 idle cycles, then the byte lands on the edge that would have timed out.
    Expected = 64'h0807060504030201;
    send_bytes(64'h030201, 3);
    for (int i = 0; i < 14; i++) tick();
    send_bytes(64'h04, 1);
    total++; if ({Error, ByteCount} !== {1'b0, 4'd4}) begin bad++; $display("FAIL gap_edge_byte got=%b/%0d exp=0/4", Error, ByteCount); end
    send_bytes(64'h08070605, 4);
    total++; if ({Hash, Done, Match} !== {64'h0807060504030201, 2'b11}) begin bad++; $display("FAIL gap_edge_frame got=%h/%b exp=0807060504030201/11", Hash, {Done, Match}); end
  endtask

  task automatic test_overrun();
    send_bytes(64'hAA, 1);
    total++; if ({Overrun, Done} !== 2'b11) begin bad++; $display("FAIL overrun_set got=%b exp=11", {Overrun, Done}); end
    total++; if ({Hash, ByteCount} !== {64'h0807060504030201, 4'd8}) begin bad++; $display("FAIL overrun_hold got=%h/%0d exp=0807060504030201/8", Hash, ByteCount); end
    Byte = 8'hBB; ByteValid = 1'b1; Ack = 1'b1;
    tick();
    ByteValid = 1'b0; Ack = 1'b0;
    total++; if ({Done, Overrun, ByteCount} !== {2'b00, 4'd0}) begin bad++; $display("FAIL ack_priority got=%b/%0d exp=00/0", {Done, Overrun}, ByteCount); end
    tick();
    total++; if (ByteCount !== 4'd0) begin bad++; $display("FAIL ack_byte_dropped got=%0d exp=0", ByteCount); end
  endtask

  task automatic test_back_to_back();
    Expected = 64'hA1B2C3D4E5F60718;
    send_bytes(64'hA1B2C3D4E5F60718, 8);
    do_ack();
    Expected = 64'h1020304050607080;
    send_bytes(64'h1020304050607080, 8);
    total++; if ({Hash, Done, Match} !== {64'h1020304050607080, 2'b11}) begin bad++; $display("FAIL b2b_frame got=%h/%b exp=1020304050607080/11", Hash, {Done, Match}); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    send_bytes(64'h0000003333333333, 5);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    total++; if ({Hash, Done, Match, Error, Overrun, ByteCount} !== 72'h0) begin bad++; $display("FAIL midreset_outputs got=%h/%b/%0d exp=0/0000/0", Hash, {Done, Match, Error, Overrun}, ByteCount); end
    Expected = 64'h1122334455667788;
    send_bytes(64'h1122334455667788, 8);
    total++; if ({Hash, Match} !== {64'h1122334455667788, 1'b1}) begin bad++; $display("FAIL midreset_frame got=%h/%b exp=1122334455667788/1", Hash, Match); end
    do_ack();
  endtask

  // Bench-side transmitter: emits its hash low byte first while not done.
  task automatic test_loopback();
    logic [63:0] tx;
    int          sent;
    tx = 64'hDEADBEEFCAFEF00D;
    sent = 0;
    Expected = 64'hDEADBEEFCAFEF00D;
    while (sent < 8) begin
      Byte = tx[7:0]; ByteValid = 1'b1;
      tx = tx >> 8; sent++;
      tick();
    end
    ByteValid = 1'b0;
    total++; if ({Hash, Done, Match} !== {64'hDEADBEEFCAFEF00D, 2'b11}) begin bad++; $display("FAIL loopback got=%h/%b exp=deadbeefcafef00d/11", Hash, {Done, Match}); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_mismatch();
    test_gap();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
